// File: rtl/line_evt_pkg.sv
// Shared constants and selection helpers for the line event arbiter.
// The helper functions operate on N_DEF-bit vectors; N must not exceed N_DEF.
package line_evt_pkg;

   localparam int unsigned N_DEF           = 8;
   localparam int unsigned SYNC_STAGES_DEF = 2;

   // Keep only the lowest set bit (two's-complement trick).
   function automatic logic [N_DEF-1:0] onehot_lowest(input logic [N_DEF-1:0] vec);
      return vec & (~vec + N_DEF'(1));
   endfunction

   // Rotate the low n bits of vec by amt (amt < n).
   // Right: res[i] = vec[(i+amt) mod n]; left: res[(i+amt) mod n] = vec[i].
   function automatic logic [N_DEF-1:0] onehot_rotate(input logic [N_DEF-1:0] vec,
                                                      input int unsigned     amt,
                                                      input int unsigned     n,
                                                      input logic            left);
      logic [N_DEF-1:0] res;
      int unsigned      j;
      res = '0;
      for (int unsigned i = 0; i < N_DEF; i++) begin
         if (i < n) begin
            j = i + amt;
            if (j >= n) j = j - n;
            if (left) res[j] = vec[i];
            else      res[i] = vec[j];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/line_sync.sv
// N-wide multi-flop synchroniser with a history flop; flags rising edges.
module line_sync #(
   parameter int unsigned N           = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] line_in,
   output logic [N-1:0] line_edge
);

   logic [N-1:0] sync_q [SYNC_STAGES];
   logic [N-1:0] hist_q;

   // Shift the raw lines through the synchroniser chain, then into history.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         hist_q <= '0;
      end else begin
         sync_q[0] <= line_in;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign line_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/line_event_arbiter.sv
// Line event arbiter: synchronises N event lines, latches rising edges as pending
// flags and hands them out one at a time as a registered one-hot word (valid/ready).
// Define LINE_EVENT_ARBITER_RR_EN for round-robin selection; default is lowest index first.
module line_event_arbiter
   import line_evt_pkg::*;
#(
   parameter int unsigned N           = N_DEF,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] line_in,
   output logic [N-1:0] ev_onehot,
   output logic         ev_valid,
   input  logic         ev_ready,
   output logic [N-1:0] pending,
   output logic         overrun,
   input  logic         clr_overrun
);

   logic [N-1:0]     line_edge;
   logic [N-1:0]     pending_q, pending_d;
   logic [N-1:0]     ev_onehot_q, ev_onehot_d;
   logic             ev_valid_q, ev_valid_d;
   logic             overrun_q, overrun_d;
   logic [N-1:0]     sel, load_mask;
   logic [N_DEF-1:0] pend_ext, sel_ext;
   logic             slot_free, load, ovr_evt;

   line_sync #(
      .N           (N),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .clk       (clk),
      .rst       (rst),
      .line_in   (line_in),
      .line_edge (line_edge)
   );

   assign pend_ext = N_DEF'(pending_q);

`ifdef LINE_EVENT_ARBITER_RR_EN
   localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

   logic [PtrW-1:0]  last_q, last_d;
   logic [N_DEF-1:0] rot;
   int unsigned      start;

   // Search from the slot after the last grant: rotate it to bit 0, pick lowest, rotate back.
   always_comb begin
      start   = (32'(last_q) == N - 1) ? 0 : 32'(last_q) + 1;
      rot     = onehot_rotate(pend_ext, start, N, 1'b0);
      sel_ext = onehot_rotate(onehot_lowest(rot), start, N, 1'b1);
   end

   // Remember the index of each granted event.
   always_comb begin
      last_d = last_q;
      if (load) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (sel[i]) last_d = PtrW'(i);
         end
      end
   end

   // Last-grant pointer; reset to N-1 so index 0 is favoured first.
   always_ff @(posedge clk) begin
      if (rst) last_q <= PtrW'(N - 1);
      else     last_q <= last_d;
   end
`else
   assign sel_ext = onehot_lowest(pend_ext);
`endif

   assign sel = sel_ext[N-1:0];

   // Load/pending/overrun next-state; an edge on the bit being loaded simply re-pends it.
   always_comb begin
      slot_free = ~ev_valid_q | ev_ready;
      load      = slot_free & (|pending_q);
      load_mask = load ? sel : '0;
      pending_d = (pending_q & ~load_mask) | line_edge;
      ovr_evt   = |(line_edge & pending_q & ~load_mask);

      overrun_d = overrun_q;
      if (ovr_evt)          overrun_d = 1'b1;
      else if (clr_overrun) overrun_d = 1'b0;

      ev_onehot_d = ev_onehot_q;
      ev_valid_d  = ev_valid_q;
      if (slot_free) begin
         ev_onehot_d = load_mask;
         ev_valid_d  = load;
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q   <= '0;
         ev_onehot_q <= '0;
         ev_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         ev_onehot_q <= ev_onehot_d;
         ev_valid_q  <= ev_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign ev_onehot = ev_onehot_q;
   assign ev_valid  = ev_valid_q;
   assign pending   = pending_q;
   assign overrun   = overrun_q;

endmodule
